sa_tile_loader: RTL and testbench

Upstream feeder for the systolic array. Accepts a stream of operand vectors (one lane-wide vector per beat, tagged weight or input) and writes each vector into the array's per-lane weight or input FIFOs. After a full tile of both operands is loaded, it pulses the array's `start`, waits for `done` and then for a release from the downstream result reader. Finally it pulses `clr` so the array is ready for the next tile.

---
 rtl/sa_pkg.sv | 19 +
 rtl/sa_tile_loader_if.sv | 16 +
 rtl/sa_beat_counter.sv | 43 ++++
 rtl/sa_tile_loader.sv | 142 ++++++++++++++
 tb/tb_sa_tile_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared types for the systolic-array tile loader: FSM state encoding and
// the default-geometry lane-vector type.
package sa_pkg;

  localparam int unsigned SA_ARRAY_SIZE = 16;
  localparam int unsigned SA_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    HOLD  = 3'd3,
    CLR   = 3'd4
  } sa_load_state_t;

  // Lane k occupies element [k], matching in_data[k*DATA_WIDTH +: DATA_WIDTH].
  typedef logic [SA_ARRAY_SIZE-1:0][SA_DATA_WIDTH-1:0] sa_lane_vec_t;

endpackage

// File: rtl/sa_tile_loader_if.sv
// Operand beat stream into the tile loader: one lane-wide vector per beat,
// tagged weight (in_sel=0) or input (in_sel=1).
interface sa_tile_loader_if #(
  parameter int unsigned ARRAY_SIZE = 16,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                             in_valid;
  logic                             in_ready;
  logic                             in_sel;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_sel, output in_data, input in_ready);
  modport slave  (input in_valid, input in_sel, input in_data, output in_ready);

endinterface

// File: rtl/sa_beat_counter.sv
// Saturating beat counter; at_max_next reports the value after this edge so
// the loader can leave LOAD on the very edge that accepts the last beat.
module sa_beat_counter #(
  parameter int unsigned MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max,
  output logic at_max_next
);

  localparam int unsigned CW = $clog2(MAX) + 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins over increment, increment stops at MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign at_max      = (cnt_q == CW'(MAX));
  assign at_max_next = (cnt_d == CW'(MAX));

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sa_tile_loader.sv
// Loads one tile of weight and input vectors into the array FIFOs, then
// sequences start -> done -> release -> clear before accepting the next tile.
module sa_tile_loader
  import sa_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TILE_DEPTH = ARRAY_SIZE
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  sa_tile_loader_if.slave                      in_if,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] weights,
  output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] inputs,
  output logic [ARRAY_SIZE-1:0]                wren_w,
  output logic [ARRAY_SIZE-1:0]                wren_i,
  input  logic [ARRAY_SIZE-1:0]                full_w,
  input  logic [ARRAY_SIZE-1:0]                full_i,
  output logic                                 sa_start,
  output logic                                 sa_clr,
  input  logic                                 sa_done,
  // "release" is a reserved word, hence the prefix.
  input  logic                                 sa_release,
  output logic                                 tile_done,
  output logic                                 busy,
  output logic [15:0]                          tile_cnt
);

  localparam logic [2:0] ST_LOAD  = 3'(LOAD);
  localparam logic [2:0] ST_START = 3'(START);
  localparam logic [2:0] ST_RUN   = 3'(RUN);
  localparam logic [2:0] ST_HOLD  = 3'(HOLD);
  localparam logic [2:0] ST_CLR   = 3'(CLR);

  logic [2:0]  state_q, state_d;
  logic [15:0] tile_cnt_q, tile_cnt_d;
  logic        start_q, start_d;
  logic        clr_q, clr_d;
  logic        tile_done_q, tile_done_d;
  logic        busy_q, busy_d;

  logic w_at_max, w_done_next;
  logic i_at_max, i_done_next;
  logic in_ready_s;
  logic acc_w_s, acc_i_s;

  // ready depends on the tagged operand only, so a complete operand blocks the stream
  always_comb begin
    in_ready_s = 1'b0;
    if (state_q != ST_LOAD) begin
      in_ready_s = 1'b0;
    end else if (in_if.in_sel) begin
      in_ready_s = !i_at_max && !(|full_i);
    end else begin
      in_ready_s = !w_at_max && !(|full_w);
    end
  end

  assign in_if.in_ready = in_ready_s;
  assign acc_w_s = in_if.in_valid && in_ready_s && !in_if.in_sel;
  assign acc_i_s = in_if.in_valid && in_ready_s &&  in_if.in_sel;

  assign weights = in_if.in_data;
  assign inputs  = in_if.in_data;
  assign wren_w  = {ARRAY_SIZE{acc_w_s}};
  assign wren_i  = {ARRAY_SIZE{acc_i_s}};

  sa_beat_counter #(.MAX(TILE_DEPTH)) u_w_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (acc_w_s),
    .clr         (state_q == ST_CLR),
    .at_max      (w_at_max),
    .at_max_next (w_done_next)
  );

  sa_beat_counter #(.MAX(TILE_DEPTH)) u_i_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (acc_i_s),
    .clr         (state_q == ST_CLR),
    .at_max      (i_at_max),
    .at_max_next (i_done_next)
  );

  // tile sequencing; outputs are decoded from the next state so they register cleanly
  always_comb begin
    state_d    = state_q;
    tile_cnt_d = tile_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (w_done_next && i_done_next) state_d = ST_START;
        else                            state_d = ST_LOAD;
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (sa_done) begin
          state_d    = ST_HOLD;
          tile_cnt_d = tile_cnt_q + 16'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (sa_release) state_d = ST_CLR;
        else            state_d = ST_HOLD;
      end
      ST_CLR:  state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
    start_d     = (state_d == ST_START);
    clr_d       = (state_d == ST_CLR);
    tile_done_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_LOAD);
  end

  // state, tile counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      tile_cnt_q  <= 16'd0;
      start_q     <= 1'b0;
      clr_q       <= 1'b0;
      tile_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_cnt_q  <= tile_cnt_d;
      start_q     <= start_d;
      clr_q       <= clr_d;
      tile_done_q <= tile_done_d;
      busy_q      <= busy_d;
    end
  end

  assign sa_start  = start_q;
  assign sa_clr    = clr_q;
  assign tile_done = tile_done_q;
  assign busy      = busy_q;
  assign tile_cnt  = tile_cnt_q;

endmodule

// File: tb/tb_sa_tile_loader.sv
// Scoreboard bench for sa_tile_loader at ARRAY_SIZE=4, TILE_DEPTH=4.
module tb_sa_tile_loader;

  localparam int AS = 4;
  localparam int DW = 8;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_tile_loader_if #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW)) bus ();

  logic [AS-1:0][DW-1:0] weights, inputs;
  logic [AS-1:0] wren_w, wren_i, full_w, full_i;
  logic sa_start, sa_clr, sa_done, sa_release, tile_done, busy;
  logic [15:0] tile_cnt;

  sa_tile_loader #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .TILE_DEPTH(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (bus),
    .weights    (weights),
    .inputs     (inputs),
    .wren_w     (wren_w),
    .wren_i     (wren_i),
    .full_w     (full_w),
    .full_i     (full_i),
    .sa_start   (sa_start),
    .sa_clr     (sa_clr),
    .sa_done    (sa_done),
    .sa_release (sa_release),
    .tile_done  (tile_done),
    .busy       (busy),
    .tile_cnt   (tile_cnt)
  );

  typedef struct packed {
    logic              sel;
    logic [AS*DW-1:0]  data;
  } beat_t;

  beat_t       sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          m_w = 0;
  int          m_i = 0;
  bit          m_load = 1'b1;
  logic [15:0] m_tiles = 16'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; the model predicts acceptance and queues the expected write.
  task automatic drive(input logic v, input logic sel, input logic [AS*DW-1:0] data);
    logic  exp_rdy, exp_acc;
    beat_t b;
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = data;
    exp_rdy = m_load && (sel ? (m_i < TD) : (m_w < TD)) && !(sel ? (|full_i) : (|full_w));
    exp_acc = v && exp_rdy;
    if (exp_acc) begin
      sb_q.push_back('{sel: sel, data: data});
      if (sel) m_i++;
      else     m_w++;
    end
    @(negedge clk);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("wren_any", 64'(|{wren_w, wren_i}), 64'(exp_acc));
    if (|{wren_w, wren_i}) begin
      if (sb_q.size() == 0) begin
        chk("sb_depth", 64'(sb_q.size()), 64'd1);
      end else begin
        b = sb_q.pop_front();
        chk("wren_w", 64'(wren_w), b.sel ? 64'h0 : 64'hF);
        chk("wren_i", 64'(wren_i), b.sel ? 64'hF : 64'h0);
        if (b.sel) chk("inputs", 64'(inputs), 64'(b.data));
        else       chk("weights", 64'(weights), 64'(b.data));
      end
    end
    tick();
    if (m_w == TD && m_i == TD) m_load = 1'b0;
  endtask

  task automatic load_random();
    for (int k = 0; k < TD; k++) begin
      drive(1'b1, 1'b0, $urandom);
      drive(1'b1, 1'b1, $urandom);
    end
  endtask

  // Called in the START cycle; walks RUN, HOLD and CLR back into LOAD.
  task automatic finish_tile(input int rel_dly, input bit done_with_rel);
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    chk("start_pulse", 64'(sa_start), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_clr", 64'(sa_clr), 64'd0);
    chk("start_ready", 64'(bus.in_ready), 64'd0);
    sa_release = 1'b1;
    tick();
    sa_release = 1'b0;
    chk("start_width", 64'(sa_start), 64'd0);
    chk("run_done", 64'(tile_done), 64'd0);
    sa_release = 1'b1;
    tick();
    sa_release = 1'b0;
    chk("run_ign_rel", 64'(tile_done), 64'd0);
    chk("run_busy", 64'(busy), 64'd1);
    sa_done    = 1'b1;
    sa_release = done_with_rel;
    tick();
    sa_done    = 1'b0;
    sa_release = 1'b0;
    m_tiles    = m_tiles + 16'd1;
    for (int k = 0; k < rel_dly; k++) begin
      chk("hold_done", 64'(tile_done), 64'd1);
      chk("hold_cnt", 64'(tile_cnt), 64'(m_tiles));
      chk("hold_clr", 64'(sa_clr), 64'd0);
      chk("hold_ready", 64'(bus.in_ready), 64'd0);
      sa_done    = (k == 0);
      sa_release = (k == rel_dly - 1);
      tick();
    end
    sa_done    = 1'b0;
    sa_release = 1'b0;
    chk("clr_pulse", 64'(sa_clr), 64'd1);
    chk("clr_done", 64'(tile_done), 64'd0);
    chk("clr_start", 64'(sa_start), 64'd0);
    chk("clr_busy", 64'(busy), 64'd1);
    tick();
    chk("clr_width", 64'(sa_clr), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ready", 64'(bus.in_ready), 64'd1);
    chk("idle_cnt", 64'(tile_cnt), 64'(m_tiles));
    m_w    = 0;
    m_i    = 0;
    m_load = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AS*DW-1:0] wv, iv;
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    bus.in_data  = '0;
    full_w       = '0;
    full_i       = '0;
    sa_done      = 1'b0;
    sa_release   = 1'b0;
    #1;
    chk("rst_start", 64'(sa_start), 64'd0);
    chk("rst_clr", 64'(sa_clr), 64'd0);
    chk("rst_done", 64'(tile_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(tile_cnt), 64'd0);
    chk("rst_wren", 64'({wren_w, wren_i}), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    #7 rst_n = 1'b1;
    tick();

    // basic tile: lanes {1,2,3,4} weights then {5,6,7,8} inputs
    wv = {8'd4, 8'd3, 8'd2, 8'd1};
    iv = {8'd8, 8'd7, 8'd6, 8'd5};
    for (int k = 0; k < TD; k++) drive(1'b1, 1'b0, wv);
    for (int k = 0; k < TD; k++) drive(1'b1, 1'b1, iv);
    finish_tile(5, 1'b0);

    // interleaved, then a fifth weight beat must stall
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, $urandom);
      drive(1'b1, 1'b1, $urandom);
    end
    drive(1'b1, 1'b0, $urandom);
    drive(1'b1, 1'b0, $urandom);
    drive(1'b1, 1'b0, $urandom);
    drive(1'b1, 1'b1, $urandom);
    finish_tile(2, 1'b1);

    // full_i[2] high for three cycles mid-load
    drive(1'b1, 1'b0, $urandom);
    drive(1'b1, 1'b1, $urandom);
    full_i = 4'b0100;
    drive(1'b1, 1'b1, $urandom);
    drive(1'b1, 1'b0, $urandom);
    drive(1'b1, 1'b1, $urandom);
    full_i = 4'b0000;
    full_w = 4'b1000;
    drive(1'b1, 1'b0, $urandom);
    full_w = 4'b0000;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, $urandom);
    drive(1'b1, 1'b0, $urandom);
    drive(1'b1, 1'b0, $urandom);
    finish_tile(1, 1'b0);

    // reset while in RUN
    load_random();
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", 64'(sa_start), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(tile_done), 64'd0);
    chk("mid_rst_cnt", 64'(tile_cnt), 64'd0);
    chk("mid_rst_clr", 64'(sa_clr), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    m_w     = 0;
    m_i     = 0;
    m_load  = 1'b1;
    m_tiles = 16'd0;
    #3 rst_n = 1'b1;
    tick();
    load_random();
    finish_tile(3, 1'b0);

    // tile counter wrap
    force dut.tile_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.tile_cnt_q;
    tick();
    m_tiles = 16'hFFFF;
    chk("wrap_pre", 64'(tile_cnt), 64'(m_tiles));
    load_random();
    finish_tile(2, 1'b0);
    chk("wrap_zero", 64'(tile_cnt), 64'd0);

    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
